// File: rtl/pid_arbiter_if.sv
// Bus bundle between pid_arbiter, its requesting control loops and the shared PID engine.
// The slave modport is the arbiter's view; the master modport is the requester/engine side.
interface pid_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 8
);
  localparam int unsigned CW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Requester side
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_setpoint;
  logic [N_REQ*DW-1:0] req_feedback;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       result;

  // Engine side
  logic                eng_start;
  logic [CW-1:0]       eng_chan;
  logic [DW-1:0]       eng_setpoint;
  logic [DW-1:0]       eng_feedback;
  logic                eng_done;
  logic [DW-1:0]       eng_result;

  // Status
  logic                timeout_err;
  logic                busy;

  modport master (
    output req, req_setpoint, req_feedback, eng_done, eng_result,
    input  ack, result, eng_start, eng_chan, eng_setpoint, eng_feedback, timeout_err, busy
  );

  modport slave (
    input  req, req_setpoint, req_feedback, eng_done, eng_result,
    output ack, result, eng_start, eng_chan, eng_setpoint, eng_feedback, timeout_err, busy
  );
endinterface

// File: rtl/pid_arbiter.sv
// Round-robin arbiter time-sharing one PID engine among N_REQ control loops.
// Flow per transaction: IDLE (arbitrate, latch operands) -> ISSUE (start pulse) ->
// WAIT (until engine done) -> RESP (one-cycle ack with result).
// Optional watchdog on WAIT enabled by defining PID_ARB_TIMEOUT_EN.
module pid_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  pid_arbiter_if.slave arb_io
);
  localparam int unsigned CW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state_q;
  logic [CW-1:0]    chan_q;
  logic [CW-1:0]    last_grant_q;
  logic [DW-1:0]    sp_q;
  logic [DW-1:0]    fb_q;
  logic [DW-1:0]    result_q;
  logic [N_REQ-1:0] ack_q;
  logic             start_q;
  logic             busy_q;

  logic             pick_vld;
  logic [CW-1:0]    pick_idx;

`ifdef PID_ARB_TIMEOUT_EN
  logic [7:0]       wait_cnt_q;
  logic             timeout_err_q;
`endif

  // Rotating-priority search starting just after the last served channel.
  always_comb begin
    logic [CW-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = CW'((32'(last_grant_q) + k) % N_REQ);
      if (!pick_vld && arb_io.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Control FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      chan_q        <= '0;
      last_grant_q  <= CW'(N_REQ - 1);
      sp_q          <= '0;
      fb_q          <= '0;
      result_q      <= '0;
      ack_q         <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
`ifdef PID_ARB_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      // Pulsed outputs default low; result is only visible alongside ack.
      start_q  <= 1'b0;
      ack_q    <= '0;
      result_q <= '0;
`ifdef PID_ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (pick_vld) begin
            chan_q  <= pick_idx;
            sp_q    <= arb_io.req_setpoint[pick_idx*DW +: DW];
            fb_q    <= arb_io.req_feedback[pick_idx*DW +: DW];
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
`ifdef PID_ARB_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          if (arb_io.eng_done) begin
            // Done beats a watchdog expiry in the same cycle.
            result_q <= arb_io.eng_result;
            ack_q    <= N_REQ'(1) << chan_q;
            state_q  <= StResp;
          end
`ifdef PID_ARB_TIMEOUT_EN
          else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
            wait_cnt_q    <= 8'(TIMEOUT);
            ack_q         <= N_REQ'(1) << chan_q;
            timeout_err_q <= 1'b1;
            state_q       <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        StResp: begin
          last_grant_q <= chan_q;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign arb_io.ack          = ack_q;
  assign arb_io.result       = result_q;
  assign arb_io.eng_start    = start_q;
  assign arb_io.eng_chan     = chan_q;
  assign arb_io.eng_setpoint = sp_q;
  assign arb_io.eng_feedback = fb_q;
  assign arb_io.busy         = busy_q;

`ifdef PID_ARB_TIMEOUT_EN
  assign arb_io.timeout_err = timeout_err_q;
`else
  // Watchdog absent: WAIT never gives up.
  assign arb_io.timeout_err = 1'b0;
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

endmodule

// File: tb/tb_pid_arbiter.sv
// Self-checking bench for pid_arbiter: directed scenarios plus randomized traffic scored
// against a transaction-level round-robin model and a toy engine (sp + 2*fb).
module tb_pid_arbiter;
  localparam int unsigned NReq = 4;
  localparam int unsigned Dw   = 8;
  localparam int unsigned Tmo  = 5;

  typedef struct {
    int         cyc;
    int         chan;
    int         exp_chan;
    logic [7:0] sp;
    logic [7:0] fb;
    logic [7:0] exp_sp;
    logic [7:0] exp_fb;
  } iss_t;

  typedef struct {
    int         cyc;
    logic [3:0] ack;
    logic [7:0] res;
    logic       terr;
  } ack_t;

  logic clk;
  logic rst;

  pid_arbiter_if #(.N_REQ(NReq), .DW(Dw)) bus ();

  pid_arbiter #(.N_REQ(NReq), .DW(Dw), .TIMEOUT(Tmo)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total;
  int         bad;
  int         cyc;
  int         lat;       // engine latency in WAIT cycles; 0 = never done
  int         cnt_dn;
  int         model_lg;
  int         terr_cnt;
  int         cur_chan;
  bit         hold_req;
  logic [7:0] cur_res;
  logic [7:0] sp_arr [NReq];
  logic [7:0] fb_arr [NReq];
  iss_t       iss_q [$];
  ack_t       ack_q [$];
  ack_t       exp_q [$];

  function automatic int rr_pick(logic [3:0] mask, int lg);
    int c;
    for (int k = 1; k <= 4; k++) begin
      c = (lg + k) % 4;
      if (mask[c[1:0]]) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] eng_fn(logic [7:0] sp, logic [7:0] fb);
    return sp + {fb[6:0], 1'b0};
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      bus.req_setpoint[i*8 +: 8] = sp_arr[i];
      bus.req_feedback[i*8 +: 8] = fb_arr[i];
    end
  endtask

  // Advance one clock, then act as engine, requester and monitor.
  task automatic tick();
    logic [3:0] mask;
    logic [7:0] sp_snap [NReq];
    logic [7:0] fb_snap [NReq];
    iss_t       r;
    ack_t       a;
    int         e;
    mask    = bus.req;
    sp_snap = sp_arr;
    fb_snap = fb_arr;
    @(posedge clk);
    #1;
    cyc++;
    bus.eng_done   = 1'b0;
    bus.eng_result = '0;
    if (bus.eng_start) begin
      e          = rr_pick(mask, model_lg);
      r.cyc      = cyc;
      r.chan     = int'(bus.eng_chan);
      r.exp_chan = e;
      r.sp       = bus.eng_setpoint;
      r.fb       = bus.eng_feedback;
      r.exp_sp   = (e >= 0) ? sp_snap[e[1:0]] : 8'h00;
      r.exp_fb   = (e >= 0) ? fb_snap[e[1:0]] : 8'h00;
      iss_q.push_back(r);
      if (e >= 0) begin
        model_lg = e;
        cur_chan = e;
        cur_res  = eng_fn(r.exp_sp, r.exp_fb);
      end
      cnt_dn = lat;
    end else if (cnt_dn > 0) begin
      cnt_dn--;
      if (cnt_dn == 0) begin
        bus.eng_done   = 1'b1;
        bus.eng_result = cur_res;
        a.cyc  = cyc + 1;
        a.ack  = 4'b0001 << cur_chan;
        a.res  = cur_res;
        a.terr = 1'b0;
        exp_q.push_back(a);
      end
    end
    if (bus.timeout_err) terr_cnt++;
    if (bus.ack != '0) begin
      a.cyc  = cyc;
      a.ack  = bus.ack;
      a.res  = bus.result;
      a.terr = bus.timeout_err;
      ack_q.push_back(a);
      if (!hold_req) bus.req = bus.req & ~bus.ack;
    end
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    bus.req      = '0;
    bus.eng_done = 1'b0;
    cnt_dn       = 0;
    model_lg     = NReq - 1;
    repeat (2) tick();
    rst = 1'b0;
    iss_q.delete();
    ack_q.delete();
    exp_q.delete();
    terr_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if (bus.ack !== 4'b0) begin bad++; $display("FAIL reset_ack: got %b want 0000", bus.ack); end
    total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", bus.result); end
    total++; if (bus.eng_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", bus.eng_start); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL reset_terr: got %b want 0", bus.timeout_err); end
    total++; if ({bus.eng_chan, bus.eng_setpoint, bus.eng_feedback} !== 18'h0) begin
      bad++; $display("FAIL reset_eng_ops: got %h want 0", {bus.eng_chan, bus.eng_setpoint, bus.eng_feedback});
    end
    apply_reset();
    repeat (3) tick();
    total++; if (bus.busy !== 1'b0 || iss_q.size() != 0) begin
      bad++; $display("FAIL idle_no_req: busy %b issues %0d want 0/0", bus.busy, iss_q.size());
    end
  endtask

  task automatic test_single();
    int c0;
    lat       = 3;
    hold_req  = 1'b0;
    sp_arr[2] = 8'h40;
    fb_arr[2] = 8'h10;
    drive_ops();
    c0      = cyc;
    bus.req = 4'b0100;
    for (int t = 0; t < 20 && ack_q.size() == 0; t++) tick();
    repeat (2) tick();
    total++; if (iss_q.size() != 1) begin bad++; $display("FAIL single_issues: got %0d want 1", iss_q.size()); end
    else begin
      total++; if (iss_q[0].chan != 2) begin bad++; $display("FAIL single_chan: got %0d want 2", iss_q[0].chan); end
      total++; if (iss_q[0].sp !== 8'h40 || iss_q[0].fb !== 8'h10) begin
        bad++; $display("FAIL single_ops: got %h/%h want 40/10", iss_q[0].sp, iss_q[0].fb);
      end
      total++; if (iss_q[0].cyc != c0 + 1) begin bad++; $display("FAIL single_issue_cyc: got %0d want %0d", iss_q[0].cyc, c0 + 1); end
    end
    total++; if (ack_q.size() != 1) begin bad++; $display("FAIL single_acks: got %0d want 1", ack_q.size()); end
    else begin
      total++; if (ack_q[0].ack !== 4'b0100) begin bad++; $display("FAIL single_ack: got %b want 0100", ack_q[0].ack); end
      total++; if (ack_q[0].res !== 8'h60) begin bad++; $display("FAIL single_result: got %h want 60", ack_q[0].res); end
      total++; if (ack_q[0].cyc != c0 + 5) begin bad++; $display("FAIL single_ack_cyc: got %0d want %0d", ack_q[0].cyc, c0 + 5); end
    end
    total++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0 || bus.result !== 8'h00) begin
      bad++; $display("FAIL single_after: busy %b ack %b result %h want 0/0/0", bus.busy, bus.ack, bus.result);
    end
  endtask

  task automatic test_fairness();
    int order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    lat      = 1;
    hold_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sp_arr[i] = 8'($urandom);
      fb_arr[i] = 8'($urandom);
    end
    drive_ops();
    bus.req = 4'b1111;
    for (int t = 0; t < 40 && ack_q.size() < 5; t++) tick();
    bus.req  = '0;
    hold_req = 1'b0;
    repeat (3) tick();
    total++; if (iss_q.size() != 5 || ack_q.size() != 5 || exp_q.size() != 5) begin
      bad++; $display("FAIL fair_count: issues %0d acks %0d exp %0d want 5", iss_q.size(), ack_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++; if (iss_q[i].chan != order[i] || iss_q[i].exp_chan != order[i]) begin
          bad++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, iss_q[i].chan, order[i]);
        end
        total++; if (ack_q[i].ack !== exp_q[i].ack || ack_q[i].res !== exp_q[i].res) begin
          bad++; $display("FAIL fair_ack[%0d]: got %b/%h want %b/%h", i, ack_q[i].ack, ack_q[i].res,
                          exp_q[i].ack, exp_q[i].res);
        end
        if (i > 0) begin
          total++; if (ack_q[i].cyc - ack_q[i-1].cyc != 4) begin
            bad++; $display("FAIL fair_spacing[%0d]: got %0d want 4", i, ack_q[i].cyc - ack_q[i-1].cyc);
          end
        end
      end
    end
  endtask

  task automatic test_operand_hold();
    iss_q.delete(); ack_q.delete(); exp_q.delete();
    lat       = 4;
    sp_arr[1] = 8'h20;
    fb_arr[1] = 8'h05;
    drive_ops();
    bus.req = 4'b0010;
    for (int t = 0; t < 10 && iss_q.size() == 0; t++) tick();
    // New operands and an early drop must not disturb the running transaction.
    sp_arr[1]  = 8'h80;
    drive_ops();
    bus.req[1] = 1'b0;
    for (int t = 0; t < 10 && ack_q.size() == 0; t++) begin
      tick();
      if (ack_q.size() == 0) begin
        total++; if (bus.eng_setpoint !== 8'h20) begin
          bad++; $display("FAIL hold_setpoint: got %h want 20", bus.eng_setpoint);
        end
      end
    end
    total++; if (ack_q.size() != 1) begin bad++; $display("FAIL hold_acks: got %0d want 1", ack_q.size()); end
    else begin
      total++; if (ack_q[0].ack !== 4'b0010 || ack_q[0].res !== 8'h2A) begin
        bad++; $display("FAIL hold_ack: got %b/%h want 0010/2a", ack_q[0].ack, ack_q[0].res);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int order [4] = '{0, 1, 2, 3};
    apply_reset();
    lat       = 0;
    sp_arr[3] = 8'h33;
    drive_ops();
    bus.req = 4'b1000;
    for (int t = 0; t < 10 && iss_q.size() == 0; t++) tick();
    repeat (2) tick();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre: got %b want 1", bus.busy); end
    #2;
    rst = 1'b1;
    #1;
    total++; if ({bus.ack, bus.result, bus.eng_start, bus.busy, bus.timeout_err} !== 15'h0) begin
      bad++; $display("FAIL mid_async_outs: got %h want 0", {bus.ack, bus.result, bus.eng_start, bus.busy, bus.timeout_err});
    end
    total++; if ({bus.eng_chan, bus.eng_setpoint, bus.eng_feedback} !== 18'h0) begin
      bad++; $display("FAIL mid_async_ops: got %h want 0", {bus.eng_chan, bus.eng_setpoint, bus.eng_feedback});
    end
    cnt_dn   = 0;
    model_lg = NReq - 1;
    iss_q.delete(); ack_q.delete(); exp_q.delete();
    lat      = 1;
    bus.req  = 4'b1111;
    tick();
    total++; if (ack_q.size() != 0) begin bad++; $display("FAIL mid_no_ack: got %0d acks want 0", ack_q.size()); end
    rst = 1'b0;
    for (int t = 0; t < 40 && ack_q.size() < 4; t++) tick();
    repeat (3) tick();
    total++; if (iss_q.size() != 4 || ack_q.size() != 4) begin
      bad++; $display("FAIL mid_count: issues %0d acks %0d want 4", iss_q.size(), ack_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (iss_q[i].chan != order[i] || iss_q[i].exp_chan != order[i]) begin
          bad++; $display("FAIL mid_order[%0d]: got %0d want %0d", i, iss_q[i].chan, order[i]);
        end
        total++; if (ack_q[i].ack !== exp_q[i].ack || ack_q[i].res !== exp_q[i].res) begin
          bad++; $display("FAIL mid_ack[%0d]: got %b/%h want %b/%h", i, ack_q[i].ack, ack_q[i].res,
                          exp_q[i].ack, exp_q[i].res);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int ci;
    apply_reset();
    lat     = 0;
    bus.req = 4'b0001;
    for (int t = 0; t < 10 && iss_q.size() == 0; t++) tick();
    ci = (iss_q.size() > 0) ? iss_q[0].cyc : 0;
`ifdef PID_ARB_TIMEOUT_EN
    for (int t = 0; t < 20 && ack_q.size() == 0; t++) tick();
    repeat (2) tick();
    total++; if (ack_q.size() != 1) begin bad++; $display("FAIL tmo_acks: got %0d want 1", ack_q.size()); end
    else begin
      total++; if (ack_q[0].cyc != ci + 6) begin bad++; $display("FAIL tmo_cyc: got %0d want %0d", ack_q[0].cyc, ci + 6); end
      total++; if (ack_q[0].ack !== 4'b0001 || ack_q[0].res !== 8'h00 || ack_q[0].terr !== 1'b1) begin
        bad++; $display("FAIL tmo_resp: got %b/%h/%b want 0001/00/1", ack_q[0].ack, ack_q[0].res, ack_q[0].terr);
      end
    end
    total++; if (terr_cnt != 1) begin bad++; $display("FAIL tmo_pulse: got %0d cycles want 1", terr_cnt); end
    // last_grant moved to 0 despite the abort, so channel 1 wins next.
    lat = 1;
    bus.req = 4'b0011;
    for (int t = 0; t < 20 && ack_q.size() < 3; t++) tick();
    total++; if (iss_q.size() < 2 || iss_q[1].chan != 1 || iss_q[1].exp_chan != 1) begin
      bad++; $display("FAIL tmo_next_grant: got %0d want 1", (iss_q.size() < 2) ? -1 : iss_q[1].chan);
    end
    repeat (2) tick();
    // Done in the very cycle the watchdog would expire: done wins.
    iss_q.delete(); ack_q.delete(); exp_q.delete(); terr_cnt = 0;
    lat       = 5;
    sp_arr[2] = 8'h11;
    fb_arr[2] = 8'h22;
    drive_ops();
    bus.req = 4'b0100;
    for (int t = 0; t < 20 && ack_q.size() == 0; t++) tick();
    ci = (iss_q.size() > 0) ? iss_q[0].cyc : 0;
    total++; if (ack_q.size() != 1) begin bad++; $display("FAIL race_acks: got %0d want 1", ack_q.size()); end
    else begin
      total++; if (ack_q[0].cyc != ci + 6 || ack_q[0].res !== 8'h55 || ack_q[0].terr !== 1'b0) begin
        bad++; $display("FAIL race_resp: got cyc %0d res %h terr %b want %0d/55/0", ack_q[0].cyc,
                        ack_q[0].res, ack_q[0].terr, ci + 6);
      end
    end
`else
    repeat (40) tick();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL nowd_busy: got %b want 1", bus.busy); end
    total++; if (ack_q.size() != 0 || terr_cnt != 0) begin
      bad++; $display("FAIL nowd_idle_resp: acks %0d terr %0d want 0/0 (issue at %0d)", ack_q.size(), terr_cnt, ci);
    end
`endif
    apply_reset();
  endtask

  task automatic test_random();
    apply_reset();
    hold_req = 1'b0;
    for (int it = 0; it < 300; it++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (!bus.req[ch] && $urandom_range(3) == 0) begin
          sp_arr[ch]  = 8'($urandom);
          fb_arr[ch]  = 8'($urandom);
          drive_ops();
          bus.req[ch] = 1'b1;
        end
      end
      lat = int'($urandom_range(4, 1));
      tick();
    end
    for (int t = 0; t < 100 && bus.req != '0; t++) tick();
    repeat (6) tick();
    total++; if (iss_q.size() != ack_q.size() || ack_q.size() != exp_q.size() || iss_q.size() < 10) begin
      bad++; $display("FAIL rand_count: issues %0d acks %0d exp %0d", iss_q.size(), ack_q.size(), exp_q.size());
    end else begin
      foreach (iss_q[i]) begin
        total++; if (iss_q[i].chan != iss_q[i].exp_chan) begin
          bad++; $display("FAIL rand_grant[%0d]: got %0d want %0d", i, iss_q[i].chan, iss_q[i].exp_chan);
        end
        total++; if (iss_q[i].sp !== iss_q[i].exp_sp || iss_q[i].fb !== iss_q[i].exp_fb) begin
          bad++; $display("FAIL rand_ops[%0d]: got %h/%h want %h/%h", i, iss_q[i].sp, iss_q[i].fb,
                          iss_q[i].exp_sp, iss_q[i].exp_fb);
        end
        total++; if (ack_q[i].ack !== exp_q[i].ack || ack_q[i].res !== exp_q[i].res ||
                     ack_q[i].cyc != exp_q[i].cyc) begin
          bad++; $display("FAIL rand_ack[%0d]: got %b/%h@%0d want %b/%h@%0d", i, ack_q[i].ack, ack_q[i].res,
                          ack_q[i].cyc, exp_q[i].ack, exp_q[i].res, exp_q[i].cyc);
        end
      end
    end
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    cyc              = 0;
    lat              = 1;
    cnt_dn           = 0;
    model_lg         = NReq - 1;
    terr_cnt         = 0;
    cur_chan         = 0;
    cur_res          = '0;
    hold_req         = 1'b0;
    rst              = 1'b1;
    bus.req          = '0;
    bus.req_setpoint = '0;
    bus.req_feedback = '0;
    bus.eng_done     = 1'b0;
    bus.eng_result   = '0;
    for (int i = 0; i < 4; i++) begin
      sp_arr[i] = '0;
      fb_arr[i] = '0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_operand_hold();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/pid_arbiter.md
# pid_arbiter

Round-robin arbiter that time-shares a single PID compute engine among `N_REQ` requesting control loops. It latches a requester's setpoint/feedback, issues a start pulse to the engine, waits for the engine's done, and returns the result with a one-cycle ack. It sits between the per-loop sample logic and the shared PID datapath.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `DW`, 8, operand/result width
- `TIMEOUT`, 15, max cycles in WAIT before abort (1..255; used only with `PID_ARB_TIMEOUT_EN`)

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- `clk` in 1: clock, rising edge
- `rst` in 1: async active-high reset
- `req` in N_REQ: level request per channel, held until its ack
- `req_setpoint` in N_REQ*DW: channel i at bits [i*DW +: DW]
- `req_feedback` in N_REQ*DW: same packing
- `ack` out N_REQ: one-hot one-cycle completion pulse
- `result` out DW: valid while any `ack` bit is high
- `eng_start` out 1: one-cycle start pulse to the engine
- `eng_chan` out clog2(N_REQ): granted channel index, stable from ISSUE through RESP
- `eng_setpoint`, `eng_feedback` out DW: latched operands, stable ISSUE through RESP
- `eng_done` in 1: engine completion, one cycle
- `eng_result` in DW: engine output, valid with `eng_done`
- `timeout_err` out 1: one-cycle pulse on watchdog abort
- `busy` out 1: high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered/state-decoded.
- IDLE: if any `req` bit is set, select the first set bit searching from `last_grant+1` upward, modulo N_REQ. Latch its index and operands, then go to ISSUE. If no bit is set, stay in IDLE.
- ISSUE: `eng_start`=1 for exactly this cycle. Always go to WAIT.
- WAIT: on `eng_done`=1, latch `eng_result` and go to RESP. `eng_done` is ignored in every state other than WAIT.
- RESP: `ack[grant]`=1 and `result` = latched value. Set `last_grant`<=grant and go to IDLE.
- Requester rule: drop `req` at the same clock edge on which `ack` is sampled. A `req` still high in the next IDLE cycle counts as a new request.
- If `req` drops before its ack: the transaction still completes and the ack is still pulsed. The arbiter never cancels an issued transaction.
- Operands are sampled only in IDLE. Changes on `req_*` after the grant have no effect on the running transaction.
- `result` and `ack` are 0 outside RESP.
- Reset values: state IDLE; `last_grant`=N_REQ-1, so channel 0 wins first; all outputs 0; latched operands and result 0.
- Reset asserted mid-transaction: return to IDLE immediately. No ack is issued, and `eng_start` is not reissued.

## Timing
- `req` high at edge k (IDLE) gives ISSUE in cycle k+1 (`eng_start`=1) and WAIT from k+2.
- `eng_done` sampled at edge m (WAIT) gives RESP in cycle m+1 (`ack`=1).
- Minimum turnaround, with done in the first WAIT cycle: 4 cycles per transaction including the IDLE arbitration cycle.
- Back-to-back: IDLE follows RESP, so another channel can be granted at the edge after the ack.
- Fairness: with all N_REQ requesting continuously, each channel is served exactly once per N_REQ transactions.

## Configuration
- `PID_ARB_TIMEOUT_EN` defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle without done.
  - If `eng_done` arrives in the same cycle the counter reaches `TIMEOUT`, done wins.
  - When the counter reaches `TIMEOUT`, go to RESP with `result`=0 and `timeout_err`=1 in that RESP cycle.
  - `last_grant` still advances.
- Not defined: no counter, WAIT waits indefinitely, `timeout_err` tied to 0.

## Test plan
- Reset, then only `req[2]`=1 with setpoint=0x40, feedback=0x10; engine returns done after 3 cycles with 0x60. Required: `eng_start` one cycle with `eng_chan`=2 and operands 0x40/0x10; `ack`=4'b0100 with `result`=0x60; `busy` low afterwards.
- All four `req` held high, engine done after 1 cycle. Required: grant order 0,1,2,3,0, with `ack` pulses spaced 4 cycles apart.
- `req[1]` changes setpoint from 0x20 to 0x80 during WAIT. Required: `eng_setpoint` stays 0x20 and the ack still arrives.
- `rst` pulsed during WAIT on channel 3. Required: all outputs go to 0 asynchronously and no ack is issued. The next `req[3]` is granted only after `req[0..2]` if those are also requesting, because `last_grant`=3 after reset.
- With `PID_ARB_TIMEOUT_EN`, `TIMEOUT`=5, engine never done. Required: RESP 5 WAIT cycles after ISSUE, `ack` with `result`=0, `timeout_err` one cycle. Without the macro: stays in WAIT, `busy`=1 indefinitely.
